// File: rtl/ex_mem_pkg.sv
// Shared definitions for the EX/MEM stage: datapath widths, access-size and
// writeback-select encodings, and the alignment-legality helper.
package ex_mem_pkg;

    localparam int XLEN_P = 64;
    localparam int RD_W_P = 5;

    localparam logic [7:0] WW_BYTE   = 8'h01;
    localparam logic [7:0] WW_HALF   = 8'h03;
    localparam logic [7:0] WW_WORD   = 8'h0F;
    localparam logic [7:0] WW_DOUBLE = 8'hFF;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wb_sel_e;

    // Natural alignment per access size; unknown sizes are never legal.
    function automatic logic access_legal(input logic [7:0] width, input logic [2:0] a);
        logic legal;
        case (width)
            WW_BYTE:   legal = 1'b1;
            WW_HALF:   legal = (a[0] == 1'b0);
            WW_WORD:   legal = (a[1:0] == 2'b00);
            WW_DOUBLE: legal = (a == 3'b000);
            default:   legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/ex_mem_store_align.sv
// Combinational store lane alignment: shifts the byte mask and store data to
// the addressed lanes and flags misaligned or illegal-size accesses.
module store_align
    import ex_mem_pkg::*;
#(
    parameter int XLEN = XLEN_P
) (
    input  logic [2:0]      addr,
    input  logic [7:0]      write_width,
    input  logic [XLEN-1:0] write_data,
    output logic [7:0]      wmask,
    output logic [XLEN-1:0] wdata,
    output logic            misalign
);

    logic [7:0] shifted_mask_s;
    logic       legal_s;

    // Lane shift and legality; a misaligned access enables no lanes.
    always_comb begin
        legal_s        = access_legal(write_width, addr);
        shifted_mask_s = write_width << addr;
        wdata          = write_data << {addr, 3'b000};
        misalign       = ~legal_s;
        if (legal_s) begin
            wmask = shifted_mask_s;
        end else begin
            wmask = 8'h00;
        end
    end

endmodule

// File: rtl/ex_mem.sv
// EX/MEM pipeline register with valid/ready handshake, store lane alignment
// and misalign detection. Optional stall counter: EX_MEM_PERF_CNT_EN.
module ex_mem
    import ex_mem_pkg::*;
#(
    parameter int XLEN = XLEN_P,
    parameter int RD_W = RD_W_P
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic            ex_is_write_dmem,
    input  logic [1:0]      ex_wb_select,
    input  logic [7:0]      ex_write_width,
    input  logic [XLEN-1:0] ex_dmem_write_data,
    input  logic [RD_W-1:0] ex_rd,
    input  logic            ex_rd_we,
    input  logic            flush,
    input  logic            mem_ready,
    output logic            mem_valid,
    output logic [XLEN-1:0] mem_alu_result,
    output logic [XLEN-1:0] mem_dmem_addr,
    output logic            mem_dmem_wen,
    output logic [7:0]      mem_dmem_wmask,
    output logic [XLEN-1:0] mem_dmem_wdata,
    output logic [1:0]      mem_wb_select,
    output logic [RD_W-1:0] mem_rd,
    output logic            mem_rd_we,
    output logic            mem_misalign,
    output logic [31:0]     mem_stall_cycles
);

    logic            valid_r;
    logic [XLEN-1:0] alu_r;
    logic            wen_r;
    logic [7:0]      wmask_r;
    logic [XLEN-1:0] wdata_r;
    logic [1:0]      wb_sel_r;
    logic [RD_W-1:0] rd_r;
    logic            rd_we_r;
    logic            mis_r;

    logic [7:0]      al_wmask_s;
    logic [XLEN-1:0] al_wdata_s;
    logic            al_mis_s;
    logic            ready_s;

    store_align #(.XLEN(XLEN)) u_align (
        .addr        (ex_alu_result[2:0]),
        .write_width (ex_write_width),
        .write_data  (ex_dmem_write_data),
        .wmask       (al_wmask_s),
        .wdata       (al_wdata_s),
        .misalign    (al_mis_s)
    );

    assign ready_s = ~valid_r | mem_ready;

    // Stage register: flush beats load, load beats hold (hold keeps everything).
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            valid_r  <= 1'b0;
            alu_r    <= '0;
            wen_r    <= 1'b0;
            wmask_r  <= 8'h00;
            wdata_r  <= '0;
            wb_sel_r <= 2'b00;
            rd_r     <= '0;
            rd_we_r  <= 1'b0;
            mis_r    <= 1'b0;
        end else if (flush) begin
            valid_r  <= 1'b0;
            wen_r    <= 1'b0;
            rd_we_r  <= 1'b0;
        end else if (ready_s) begin
            valid_r  <= ex_valid;
            alu_r    <= ex_alu_result;
            wen_r    <= ex_valid & ex_is_write_dmem & ~al_mis_s;
            wmask_r  <= al_wmask_s;
            wdata_r  <= al_wdata_s;
            wb_sel_r <= ex_wb_select;
            rd_r     <= ex_rd;
            rd_we_r  <= ex_valid & ex_rd_we & ~al_mis_s;
            mis_r    <= al_mis_s;
        end
    end

`ifdef EX_MEM_PERF_CNT_EN
    logic [31:0] stall_cnt_r;

    // Saturating count of edges spent holding a live instruction.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            stall_cnt_r <= 32'd0;
        end else if (valid_r && !mem_ready && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end
    end

    assign mem_stall_cycles = stall_cnt_r;
`else
    assign mem_stall_cycles = 32'd0;
`endif

    assign ex_ready       = ready_s;
    assign mem_valid      = valid_r;
    assign mem_alu_result = alu_r;
    assign mem_dmem_addr  = {alu_r[XLEN-1:3], 3'b000};
    assign mem_dmem_wen   = wen_r;
    assign mem_dmem_wmask = wmask_r;
    assign mem_dmem_wdata = wdata_r;
    assign mem_wb_select  = wb_sel_r;
    assign mem_rd         = rd_r;
    assign mem_rd_we      = rd_we_r;
    assign mem_misalign   = mis_r;

endmodule

// File: tb/tb_ex_mem.sv
// Directed bench for ex_mem: vector table for single-cycle captures plus
// hand-written stall, flush and asynchronous-reset sequences.
module tb_ex_mem;

    logic        sys_clk;
    logic        sys_rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [63:0] ex_alu_result;
    logic        ex_is_write_dmem;
    logic [1:0]  ex_wb_select;
    logic [7:0]  ex_write_width;
    logic [63:0] ex_dmem_write_data;
    logic [4:0]  ex_rd;
    logic        ex_rd_we;
    logic        flush;
    logic        mem_ready;
    logic        mem_valid;
    logic [63:0] mem_alu_result;
    logic [63:0] mem_dmem_addr;
    logic        mem_dmem_wen;
    logic [7:0]  mem_dmem_wmask;
    logic [63:0] mem_dmem_wdata;
    logic [1:0]  mem_wb_select;
    logic [4:0]  mem_rd;
    logic        mem_rd_we;
    logic        mem_misalign;
    logic [31:0] mem_stall_cycles;

`ifdef EX_MEM_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    ex_mem dut (
        .sys_clk            (sys_clk),
        .sys_rst            (sys_rst),
        .ex_valid           (ex_valid),
        .ex_ready           (ex_ready),
        .ex_alu_result      (ex_alu_result),
        .ex_is_write_dmem   (ex_is_write_dmem),
        .ex_wb_select       (ex_wb_select),
        .ex_write_width     (ex_write_width),
        .ex_dmem_write_data (ex_dmem_write_data),
        .ex_rd              (ex_rd),
        .ex_rd_we           (ex_rd_we),
        .flush              (flush),
        .mem_ready          (mem_ready),
        .mem_valid          (mem_valid),
        .mem_alu_result     (mem_alu_result),
        .mem_dmem_addr      (mem_dmem_addr),
        .mem_dmem_wen       (mem_dmem_wen),
        .mem_dmem_wmask     (mem_dmem_wmask),
        .mem_dmem_wdata     (mem_dmem_wdata),
        .mem_wb_select      (mem_wb_select),
        .mem_rd             (mem_rd),
        .mem_rd_we          (mem_rd_we),
        .mem_misalign       (mem_misalign),
        .mem_stall_cycles   (mem_stall_cycles)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    typedef struct {
        logic        valid;
        logic [63:0] alu;
        logic        is_wr;
        logic [1:0]  wb;
        logic [7:0]  ww;
        logic [63:0] wd;
        logic [4:0]  rd;
        logic        rd_we;
        logic        e_wen;
        logic [7:0]  e_mask;
        logic [63:0] e_wdata;
        logic        e_mis;
        logic        e_rd_we;
        logic        chk_data;
    } vec_t;

    int n_vec  = 0;
    int n_fail = 0;
    int exp_stall = 0;
    vec_t vecs[12];
    vec_t va;
    vec_t vb;
    vec_t vc;

    function automatic vec_t mk(input logic valid, input logic [63:0] alu, input logic is_wr,
                                input logic [1:0] wb, input logic [7:0] ww, input logic [63:0] wd,
                                input logic [4:0] rd, input logic rd_we, input logic e_wen,
                                input logic [7:0] e_mask, input logic [63:0] e_wdata,
                                input logic e_mis, input logic e_rd_we, input logic chk_data);
        vec_t v;
        v.valid = valid;   v.alu = alu;       v.is_wr = is_wr;   v.wb = wb;
        v.ww = ww;         v.wd = wd;         v.rd = rd;         v.rd_we = rd_we;
        v.e_wen = e_wen;   v.e_mask = e_mask; v.e_wdata = e_wdata;
        v.e_mis = e_mis;   v.e_rd_we = e_rd_we; v.chk_data = chk_data;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ex_valid           = v.valid;
        ex_alu_result      = v.alu;
        ex_is_write_dmem   = v.is_wr;
        ex_wb_select       = v.wb;
        ex_write_width     = v.ww;
        ex_dmem_write_data = v.wd;
        ex_rd              = v.rd;
        ex_rd_we           = v.rd_we;
    endtask

    task automatic chk_vec(input string tag, input vec_t v);
        chk({tag, ".valid"}, 64'(mem_valid), 64'(v.valid));
        chk({tag, ".wen"}, 64'(mem_dmem_wen), 64'(v.e_wen));
        chk({tag, ".rd_we"}, 64'(mem_rd_we), 64'(v.e_rd_we));
        if (v.chk_data) begin
            chk({tag, ".alu"}, mem_alu_result, v.alu);
            chk({tag, ".addr"}, mem_dmem_addr, {v.alu[63:3], 3'b000});
            chk({tag, ".wmask"}, 64'(mem_dmem_wmask), 64'(v.e_mask));
            chk({tag, ".wdata"}, mem_dmem_wdata, v.e_wdata);
            chk({tag, ".misalign"}, 64'(mem_misalign), 64'(v.e_mis));
            chk({tag, ".wb_sel"}, 64'(mem_wb_select), 64'(v.wb));
            chk({tag, ".rd"}, 64'(mem_rd), 64'(v.rd));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".valid"}, 64'(mem_valid), 64'd0);
        chk({tag, ".alu"}, mem_alu_result, 64'd0);
        chk({tag, ".addr"}, mem_dmem_addr, 64'd0);
        chk({tag, ".wen"}, 64'(mem_dmem_wen), 64'd0);
        chk({tag, ".wmask"}, 64'(mem_dmem_wmask), 64'd0);
        chk({tag, ".wdata"}, mem_dmem_wdata, 64'd0);
        chk({tag, ".wb_sel"}, 64'(mem_wb_select), 64'd0);
        chk({tag, ".rd"}, 64'(mem_rd), 64'd0);
        chk({tag, ".rd_we"}, 64'(mem_rd_we), 64'd0);
        chk({tag, ".misalign"}, 64'(mem_misalign), 64'd0);
        chk({tag, ".stall"}, 64'(mem_stall_cycles), 64'd0);
    endtask

    task automatic chk_stall(input string tag);
        chk(tag, 64'(mem_stall_cycles), PERF ? 64'(exp_stall) : 64'd0);
    endtask

    initial begin
        //            valid alu            wr    wb     ww     wd                      rd     rdwe  | wen   mask   wdata                   mis   rdwe  chk
        vecs[0]  = mk(1'b1, 64'h1000, 1'b1, 2'd0, 8'hFF, 64'h1122334455667788, 5'd5, 1'b0, 1'b1, 8'hFF, 64'h1122334455667788, 1'b0, 1'b0, 1'b1);
        vecs[1]  = mk(1'b1, 64'h1003, 1'b1, 2'd0, 8'h01, 64'hAB,               5'd6, 1'b0, 1'b1, 8'h08, 64'h00000000AB000000, 1'b0, 1'b0, 1'b1);
        vecs[2]  = mk(1'b1, 64'h1002, 1'b1, 2'd0, 8'h0F, 64'hDEADBEEF,         5'd7, 1'b1, 1'b0, 8'h00, 64'h0000DEADBEEF0000, 1'b1, 1'b0, 1'b1);
        vecs[3]  = mk(1'b1, 64'h2006, 1'b1, 2'd0, 8'h03, 64'h1234,             5'd8, 1'b0, 1'b1, 8'hC0, 64'h1234000000000000, 1'b0, 1'b0, 1'b1);
        vecs[4]  = mk(1'b1, 64'h2005, 1'b1, 2'd0, 8'h03, 64'h1234,             5'd8, 1'b0, 1'b0, 8'h00, 64'h0012340000000000, 1'b1, 1'b0, 1'b1);
        vecs[5]  = mk(1'b1, 64'h2004, 1'b1, 2'd0, 8'h0F, 64'hCAFEF00D,         5'd9, 1'b0, 1'b1, 8'hF0, 64'hCAFEF00D00000000, 1'b0, 1'b0, 1'b1);
        vecs[6]  = mk(1'b1, 64'h3008, 1'b0, 2'd1, 8'hFF, 64'h0,                5'd7, 1'b1, 1'b0, 8'hFF, 64'h0,                1'b0, 1'b1, 1'b1);
        vecs[7]  = mk(1'b1, 64'h300C, 1'b0, 2'd1, 8'hFF, 64'h0,                5'd7, 1'b1, 1'b0, 8'h00, 64'h0,                1'b1, 1'b0, 1'b1);
        vecs[8]  = mk(1'b1, 64'h4000, 1'b1, 2'd0, 8'h07, 64'h55,               5'd3, 1'b0, 1'b0, 8'h00, 64'h55,               1'b1, 1'b0, 1'b1);
        vecs[9]  = mk(1'b0, 64'h4444, 1'b1, 2'd2, 8'h01, 64'h77,               5'd4, 1'b1, 1'b0, 8'h00, 64'h0,                1'b0, 1'b0, 1'b0);
        vecs[10] = mk(1'b1, 64'h5007, 1'b0, 2'd1, 8'h01, 64'h0,                5'd0, 1'b1, 1'b0, 8'h80, 64'h0,                1'b0, 1'b1, 1'b1);
        vecs[11] = mk(1'b1, 64'h5001, 1'b0, 2'd3, 8'h03, 64'h0,                5'd31, 1'b1, 1'b0, 8'h00, 64'h0,               1'b1, 1'b0, 1'b1);

        va = mk(1'b1, 64'h6000, 1'b1, 2'd0, 8'hFF, 64'h0102030405060708, 5'd1, 1'b0, 1'b1, 8'hFF, 64'h0102030405060708, 1'b0, 1'b0, 1'b1);
        vb = mk(1'b1, 64'h6001, 1'b1, 2'd0, 8'h01, 64'h5A,               5'd2, 1'b0, 1'b1, 8'h02, 64'h5A00,             1'b0, 1'b0, 1'b1);
        vc = mk(1'b1, 64'h8004, 1'b1, 2'd0, 8'h0F, 64'h13579BDF,         5'd9, 1'b0, 1'b1, 8'hF0, 64'h13579BDF00000000, 1'b0, 1'b0, 1'b1);

        sys_rst = 1'b0;
        flush = 1'b0;
        mem_ready = 1'b1;
        drive(mk(1'b0, 64'h0, 1'b0, 2'd0, 8'h00, 64'h0, 5'd0, 1'b0, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, 1'b0));

        // Reset state
        repeat (2) @(negedge sys_clk);
        chk_all_zero("reset");
        chk("reset.ex_ready", 64'(ex_ready), 64'd1);
        sys_rst = 1'b1;
        @(negedge sys_clk);

        // Table: one capture per cycle with mem_ready high
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i]);
            @(negedge sys_clk);
            chk_vec($sformatf("v%0d", i), vecs[i]);
        end

        // Stall: capture A, hold three cycles, then B goes in after mem_ready rises
        drive(va);
        @(negedge sys_clk);
        chk_vec("stall.capA", va);
        mem_ready = 1'b0;
        drive(vb);
        #1;
        chk("stall.ex_ready_low", 64'(ex_ready), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge sys_clk);
            exp_stall++;
            chk_vec($sformatf("stall.hold%0d", k), va);
            chk($sformatf("stall.ex_ready%0d", k), 64'(ex_ready), 64'd0);
        end
        chk_stall("stall.count3");
        mem_ready = 1'b1;
        #1;
        chk("stall.ex_ready_up", 64'(ex_ready), 64'd1);
        @(negedge sys_clk);
        chk_vec("stall.capB", vb);

        // Flush with a valid EX instruction while stalled
        mem_ready = 1'b0;
        @(negedge sys_clk);
        exp_stall++;
        chk_vec("flush.holdB", vb);
        flush = 1'b1;
        drive(vc);
        @(negedge sys_clk);
        exp_stall++;
        flush = 1'b0;
        chk("flush.valid", 64'(mem_valid), 64'd0);
        chk("flush.wen", 64'(mem_dmem_wen), 64'd0);
        chk("flush.rd_we", 64'(mem_rd_we), 64'd0);
        chk("flush.ex_ready", 64'(ex_ready), 64'd1);
        chk_stall("flush.count");
        drive(vecs[9]);
        @(negedge sys_clk);
        chk("idle.valid", 64'(mem_valid), 64'd0);
        chk("idle.ex_ready", 64'(ex_ready), 64'd1);
        chk_stall("idle.count");

        // Asynchronous reset mid-stall
        mem_ready = 1'b1;
        drive(va);
        @(negedge sys_clk);
        mem_ready = 1'b0;
        @(negedge sys_clk);
        exp_stall++;
        chk_vec("rst.holdA", va);
        chk_stall("rst.pre_count");
        #2;
        sys_rst = 1'b0;
        #1;
        exp_stall = 0;
        chk_all_zero("rst.async");
        @(negedge sys_clk);
        sys_rst = 1'b1;
        mem_ready = 1'b1;
        drive(vc);
        @(negedge sys_clk);
        chk_vec("rst.after", vc);
        chk_stall("rst.after_count");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
